// File: rtl/sprite_palette_ram.sv
// Multi-bank RGB palette with one-cycle registered lookup and runtime writes.
// Optional frame-timed colour cycling is compiled in with PALETTE_CYCLE_EN.
module sprite_palette_ram #(
    parameter int IDX_W      = 4,
    parameter int NUM_PAL    = 4,
    parameter int CH_W       = 4,
    parameter int TRANSP_IDX = 0,
    parameter int CYC_LO     = 1,
    parameter int CYC_HI     = 4,
    parameter int FRAME_DIV  = 8,
    localparam int PW        = $clog2(NUM_PAL)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              rd_en,
    input  logic [PW-1:0]     pal_sel,
    input  logic [IDX_W-1:0]  index,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_pal,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_data,
    input  logic              frame_start,
    input  logic              cycle_en,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              valid,
    output logic              transparent
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CW    = 3 * CH_W;
    localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSP_IDX);

    logic [CW-1:0]    mem [NUM_PAL][DEPTH];
    logic [IDX_W-1:0] eff_idx;

`ifdef PALETTE_CYCLE_EN
    localparam int LEN  = CYC_HI - CYC_LO + 1;
    localparam int PH_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [PH_W-1:0]  PH_MAX = PH_W'(LEN - 1);
    localparam logic [FC_W-1:0]  FC_MAX = FC_W'(FRAME_DIV - 1);
    localparam logic [IDX_W:0]   LO_V   = (IDX_W+1)'(CYC_LO);
    localparam logic [IDX_W:0]   HI_V   = (IDX_W+1)'(CYC_HI);
    localparam logic [IDX_W:0]   LEN_V  = (IDX_W+1)'(LEN);

    logic [PH_W-1:0]  phase;
    logic [FC_W-1:0]  fcnt;
    logic [IDX_W:0]   off;
    logic [IDX_W:0]   rot;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fcnt  <= '0;
            phase <= '0;
        end else if (frame_start && cycle_en) begin
            if (fcnt == FC_MAX) begin
                fcnt  <= '0;
                phase <= (phase == PH_MAX) ? '0 : phase + 1'b1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // off < LEN and phase < LEN, so one conditional subtract is a full mod
    always_comb begin
        eff_idx = index;
        off     = {1'b0, index} - LO_V;
        rot     = off + (IDX_W+1)'(phase);
        if (rot >= LEN_V)
            rot = rot - LEN_V;
        if ({1'b0, index} >= LO_V && {1'b0, index} <= HI_V)
            eff_idx = IDX_W'(rot + LO_V);
    end
`else
    logic unused_cyc;
    assign unused_cyc = frame_start ^ cycle_en;

    always_comb begin
        eff_idx = index;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < DEPTH; i++)
                    mem[p][i] <= '0;
        end else if (wr_en) begin
            mem[wr_pal][wr_idx] <= wr_data;
        end
    end

    // Reads sample mem before the same-edge write lands
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            valid       <= 1'b0;
            transparent <= 1'b0;
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                {red, green, blue} <= mem[pal_sel][eff_idx];
                transparent        <= (index == TIDX);
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Directed plus randomized checks of sprite_palette_ram against a
// behavioural palette model; cycling expectations follow PALETTE_CYCLE_EN.
module tb_sprite_palette_ram;

    localparam int IDX_W = 4;
    localparam int NPAL  = 4;
    localparam int CH_W  = 4;
    localparam int CLO   = 1;
    localparam int CHI   = 4;
    localparam int LEN   = CHI - CLO + 1;
    localparam int FDIV  = 2;

    logic        Clk = 0;
    logic        Reset_n = 0;
    logic        rd_en = 0;
    logic [1:0]  pal_sel = 0;
    logic [3:0]  index = 0;
    logic        wr_en = 0;
    logic [1:0]  wr_pal = 0;
    logic [3:0]  wr_idx = 0;
    logic [11:0] wr_data = 0;
    logic        frame_start = 0;
    logic        cycle_en = 0;
    logic [3:0]  red, green, blue;
    logic        valid, transparent;

    sprite_palette_ram #(
        .IDX_W(IDX_W), .NUM_PAL(NPAL), .CH_W(CH_W), .TRANSP_IDX(0),
        .CYC_LO(CLO), .CYC_HI(CHI), .FRAME_DIV(FDIV)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rd_en(rd_en), .pal_sel(pal_sel),
        .index(index), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
        .wr_data(wr_data), .frame_start(frame_start), .cycle_en(cycle_en),
        .red(red), .green(green), .blue(blue), .valid(valid),
        .transparent(transparent)
    );

    always #5 Clk = ~Clk;

    logic [11:0] mdl [NPAL][16];
    int          pulses;
    logic [11:0] exp_rgb;
    logic        exp_t;
    int          total = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int eff(input int idx);
`ifdef PALETTE_CYCLE_EN
        int ph;
        ph = (pulses / FDIV) % LEN;
        if (idx >= CLO && idx <= CHI)
            return CLO + ((idx - CLO + ph) % LEN);
`endif
        return idx;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPAL; p++)
            for (int i = 0; i < 16; i++)
                mdl[p][i] = '0;
        pulses  = 0;
        exp_rgb = '0;
        exp_t   = 1'b0;
    endtask

    // Drive one cycle, then check the registered lookup result
    task automatic cyc(input string tag, input bit rd, input int pal, input int idx,
                       input bit we, input int wp, input int wi, input logic [11:0] wd,
                       input bit fs, input bit ce);
        rd_en = rd; pal_sel = 2'(pal); index = 4'(idx);
        wr_en = we; wr_pal = 2'(wp); wr_idx = 4'(wi); wr_data = wd;
        frame_start = fs; cycle_en = ce;
        if (rd) begin
            exp_rgb = mdl[pal][eff(idx)];
            exp_t   = (idx == 0);
        end
        @(posedge Clk); #1;
        if (we) mdl[wp][wi] = wd;
        if (fs && ce) pulses++;
        rd_en = 0; wr_en = 0; frame_start = 0;
        chk({tag, ".valid"}, 32'(valid), 32'(rd));
        chk({tag, ".rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
        chk({tag, ".transp"}, 32'(transparent), 32'(exp_t));
    endtask

    task automatic rd(input string tag, input int pal, input int idx);
        cyc(tag, 1, pal, idx, 0, 0, 0, 12'h0, 0, 0);
    endtask

    task automatic wr(input int pal, input int idx, input logic [11:0] d);
        cyc("wr", 0, 0, 0, 1, pal, idx, d, 0, 0);
    endtask

    task automatic pulse(input int n, input bit ce);
        for (int k = 0; k < n; k++)
            cyc("pulse", 0, 0, 0, 0, 0, 0, 12'h0, 1, ce);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.rgb", 32'({red, green, blue}), 32'd0);
        chk("rst.transp", 32'(transparent), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1;

        rd("b2i7", 2, 7);
        rd("b0i0", 0, 0);
        wr(1, 3, 12'hF44);
        rd("b1i3", 1, 3);
        chk("b1i3.lit", 32'({red, green, blue}), 32'hF44);
        rd("b0i3", 0, 3);
        cyc("idle", 0, 0, 0, 0, 0, 0, 12'h0, 0, 0);

        wr(0, 5, 12'hFFF);
        cyc("rbw", 1, 0, 5, 1, 0, 5, 12'hB00, 0, 0);
        chk("rbw.lit", 32'({red, green, blue}), 32'hFFF);
        rd("rbw2", 0, 5);
        chk("rbw2.lit", 32'({red, green, blue}), 32'hB00);

        wr(0, 1, 12'h111); wr(0, 2, 12'h222);
        wr(0, 3, 12'h333); wr(0, 4, 12'h444);
        pulse(2, 1);
        rd("cyc2.i1", 0, 1);
        rd("cyc2.i4", 0, 4);
        rd("cyc2.i5", 0, 5);
        pulse(6, 1);
        rd("cyc8.i1", 0, 1);
        pulse(3, 1);
        rd("cyc11.i2", 0, 2);
        pulse(5, 0);
        rd("hold.i2", 0, 2);
        rd("hold.i5", 0, 5);

        for (int n = 0; n < 400; n++) begin
            cyc("rnd", bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), bit'($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                12'($urandom), bit'($urandom_range(0, 3) == 0),
                bit'($urandom_range(0, 1)));
        end

        wr(3, 9, 12'h5A5);
        rd("pre_rst", 3, 9);
        rd_en = 1; pal_sel = 2'd3; index = 4'd9;
        #3 Reset_n = 0;
        #1;
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.rgb", 32'({red, green, blue}), 32'd0);
        chk("arst.transp", 32'(transparent), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1;
        rd_en = 0;
        model_reset();
        chk("rel.valid", 32'(valid), 32'd0);
        for (int p = 0; p < NPAL; p++)
            for (int i = 0; i < 16; i++)
                rd("clr", p, i);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
